nodf_module_status_tracker: RTL and testbench
=============================================

Name: nodf_module_status_tracker

Overview:
Synthesizable status tracker for a non-dataflow HLS block with an ap_ctrl handshake (ap_start/ap_ready/ap_done/ap_continue).
- Observes the handshake passively; never drives it.
- Classifies module status each cycle, counts accepted starts and completions, and measures per-transaction latency and start-to-start interval.
- Freezes all statistics when the simulation/test-level finish signal asserts.
- Sits beside the monitored block; outputs feed a status dump or debug registers.

Parameters:
CNT_W, 32, width of cycle counter, transaction counters, latency and interval values
MAX_OUT, 4, maximum outstanding (started, not completed) transactions tracked; power of two, >=1

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
ap_start  in  1  start request of monitored block
ap_ready  in  1  block accepts inputs this cycle
ap_done  in  1  block finished a transaction
ap_continue  in  1  downstream accepts completion (tie 1 when unused)
finish  in  1  end of test; freezes tracker
status  out  2  0 IDLE, 1 ACTIVE, 2 WAIT_CONT, 3 FINISHED
start_cnt  out  CNT_W  accepted starts
done_cnt  out  CNT_W  accepted completions
outstanding  out  $clog2(MAX_OUT)+1  transactions in flight
lat_valid  out  1  one-cycle pulse: last_latency updated
last_latency  out  CNT_W  latency of most recent completion, cycles
min_latency  out  CNT_W  smallest latency seen
max_latency  out  CNT_W  largest latency seen
int_valid  out  1  one-cycle pulse: last_interval updated
last_interval  out  CNT_W  cycles between the two most recent accepted starts
err_overflow  out  1  sticky: start accepted while MAX_OUT outstanding
err_underflow  out  1  sticky: completion with nothing outstanding
finished  out  1  sticky: finish seen

Behaviour:
- Reset (reset=0, async): all counters, outstanding, last_latency, last_interval, max_latency = 0; min_latency = all ones; pulses, errors, finished = 0; status = IDLE; cycle counter = 0.
- Cycle counter: increments every clock while not finished. Wraps modulo 2^CNT_W. Latency and interval use modular subtraction, so wrap is transparent.
- Start accept: ap_start & ap_ready at a rising edge. Pushes the current cycle count into the timestamp FIFO and increments start_cnt.
- Interval: on every accept after the first, last_interval = now - previous accept time; int_valid pulses next cycle.
- Completion accept: ap_done & ap_continue at a rising edge. Pops the oldest timestamp, sets last_latency = now - timestamp, updates min/max, increments done_cnt; lat_valid pulses next cycle.
- Output latency: all outputs are registered, with one clock of latency from the qualifying edge.
- Same-cycle start and completion, FIFO non-empty: pop the old entry and push the new one; outstanding unchanged.
- Same-cycle start and completion, FIFO empty: bypass with latency 0; outstanding stays 0; no error.
- Start when full (and no same-cycle pop): timestamp dropped, start_cnt still increments, err_overflow set.
- Completion when empty (without same-cycle start): err_underflow set; done_cnt increments; latency outputs untouched, no lat_valid.
- start_cnt and done_cnt saturate at all ones.
- Status priority: FINISHED if finished; else WAIT_CONT if ap_done & ~ap_continue; else ACTIVE if ap_start or outstanding>0; else IDLE.
- Finish: finished set at the first edge with finish=1. From then on, counters, FIFO and statistics hold their values, pulses stay 0, and handshake inputs are ignored until reset.
- Reset mid-transaction: discards all outstanding entries; no error is raised.

Decomposition:
- Package nodf_status_pkg: status enum (IDLE/ACTIVE/WAIT_CONT/FINISHED), default CNT_W, MAX_OUT.
- One sub-module, nodf_ts_fifo: MAX_OUT-deep CNT_W-wide timestamp FIFO.
  - Simultaneous push/pop; full, empty and count outputs; asynchronous active-low reset.

Test Plan:
- Reset held then released, no stimulus -> status=0, counters 0, min_latency=all ones, no pulses.
- ap_ready=1, ap_continue=1; ap_start pulse at cycle 5; ap_done pulse at cycle 12 -> last_latency=7, min=max=7, start_cnt=done_cnt=1, lat_valid one pulse.
- Starts accepted at cycles 10, 13, 20; dones at 15, 17, 30 -> latencies 5, 4, 10; last_interval 3 then 7; min=4, max=10.
- ap_done=1 with ap_continue=0 for 3 cycles, then ap_continue=1 -> status=2 for 3 cycles; completion counted once, with latency including the stall.
- MAX_OUT=4: five starts with no done -> err_overflow=1, outstanding=4, start_cnt=5. Separately, ap_done with nothing outstanding -> err_underflow=1.
- finish asserted mid-transaction -> status=3, finished=1, counters frozen despite further starts/dones. Asserting reset=0 clears everything.

Source files
------------

// File: rtl/nodf_module_status_tracker_pkg.sv
// Shared types and defaults for the ap_ctrl status tracker.
package nodf_status_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACTIVE    = 2'd1,
    WAIT_CONT = 2'd2,
    FINISHED  = 2'd3
  } status_e;

  localparam int DEF_CNT_W   = 32;
  localparam int DEF_MAX_OUT = 4;

endpackage

// File: rtl/nodf_module_status_tracker_if.sv
// ap_ctrl handshake bundle; the tracker only ever listens on the slave side.
interface nodf_module_status_tracker_if;
  logic ap_start;
  logic ap_ready;
  logic ap_done;
  logic ap_continue;

  modport master (output ap_start, ap_ready, ap_done, ap_continue);
  modport slave  (input  ap_start, ap_ready, ap_done, ap_continue);
endinterface

// File: rtl/nodf_module_status_tracker_ts_fifo.sv
// Start-timestamp FIFO; push and pop may coincide, including when full.
module nodf_ts_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic                    do_push, do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  // A pop frees the head slot in the same edge, so a full FIFO can still take a push.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clock)
    if (do_push) mem[wr_ptr] <= din;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/nodf_module_status_tracker.sv
// Passive ap_ctrl observer: status class, start/done counts, latency and start interval stats.
module nodf_module_status_tracker
  import nodf_status_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int MAX_OUT = DEF_MAX_OUT
) (
  input  logic                       clock,
  input  logic                       reset,
  nodf_module_status_tracker_if.slave hs,
  input  logic                       finish,
  output logic [1:0]                 status,
  output logic [CNT_W-1:0]           start_cnt,
  output logic [CNT_W-1:0]           done_cnt,
  output logic [$clog2(MAX_OUT):0]   outstanding,
  output logic                       lat_valid,
  output logic [CNT_W-1:0]           last_latency,
  output logic [CNT_W-1:0]           min_latency,
  output logic [CNT_W-1:0]           max_latency,
  output logic                       int_valid,
  output logic [CNT_W-1:0]           last_interval,
  output logic                       err_overflow,
  output logic                       err_underflow,
  output logic                       finished
);
  logic [CNT_W-1:0] cyc, prev_ts, head, lat_now;
  logic             have_prev;
  logic             acc_s, acc_d, f_full, f_empty, push, pop, lat_upd;
  status_e          ns;

  assign acc_s = ~finished & hs.ap_start & hs.ap_ready;
  assign acc_d = ~finished & hs.ap_done  & hs.ap_continue;

  // Start and done on an empty FIFO pair up directly: zero latency, nothing stored.
  assign push    = acc_s & ~(acc_d & f_empty);
  assign pop     = acc_d & ~f_empty;
  assign lat_upd = acc_d & (~f_empty | acc_s);
  assign lat_now = f_empty ? '0 : cyc - head;

  nodf_ts_fifo #(.W(CNT_W), .DEPTH(MAX_OUT)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (cyc),
    .dout  (head),
    .full  (f_full),
    .empty (f_empty),
    .count (outstanding)
  );

  always_comb begin
    ns = IDLE;
    if (finished | finish)                    ns = FINISHED;
    else if (hs.ap_done & ~hs.ap_continue)    ns = WAIT_CONT;
    else if (hs.ap_start | (outstanding != '0)) ns = ACTIVE;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cyc           <= '0;
      prev_ts       <= '0;
      have_prev     <= 1'b0;
      status        <= IDLE;
      start_cnt     <= '0;
      done_cnt      <= '0;
      lat_valid     <= 1'b0;
      last_latency  <= '0;
      min_latency   <= '1;
      max_latency   <= '0;
      int_valid     <= 1'b0;
      last_interval <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      finished      <= 1'b0;
    end else begin
      status    <= ns;
      finished  <= finished | finish;
      lat_valid <= lat_upd;
      int_valid <= acc_s & have_prev;
      if (!finished) cyc <= cyc + 1'b1;

      if (acc_s) begin
        if (start_cnt != '1) start_cnt <= start_cnt + 1'b1;
        if (have_prev) last_interval <= cyc - prev_ts;
        prev_ts   <= cyc;
        have_prev <= 1'b1;
        if (f_full & ~acc_d) err_overflow <= 1'b1;
      end

      if (acc_d) begin
        if (done_cnt != '1) done_cnt <= done_cnt + 1'b1;
        if (f_empty & ~acc_s) err_underflow <= 1'b1;
      end

      if (lat_upd) begin
        last_latency <= lat_now;
        if (lat_now < min_latency) min_latency <= lat_now;
        if (lat_now > max_latency) max_latency <= lat_now;
      end
    end
  end
endmodule

// File: tb/tb_nodf_module_status_tracker.sv
// Directed checks of the status tracker with hand-computed expectations.
module tb_nodf_module_status_tracker;
  localparam int CNT_W   = 32;
  localparam int MAX_OUT = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic finish = 1'b0;
  logic [1:0]           status;
  logic [CNT_W-1:0]     start_cnt, done_cnt, last_latency, min_latency, max_latency, last_interval;
  logic [$clog2(MAX_OUT):0] outstanding;
  logic lat_valid, int_valid, err_overflow, err_underflow, finished;

  int checks = 0;
  int failures = 0;

  nodf_module_status_tracker_if hs ();

  nodf_module_status_tracker #(.CNT_W(CNT_W), .MAX_OUT(MAX_OUT)) dut (
    .clock(clock), .reset(reset), .hs(hs), .finish(finish),
    .status(status), .start_cnt(start_cnt), .done_cnt(done_cnt),
    .outstanding(outstanding), .lat_valid(lat_valid), .last_latency(last_latency),
    .min_latency(min_latency), .max_latency(max_latency), .int_valid(int_valid),
    .last_interval(last_interval), .err_overflow(err_overflow),
    .err_underflow(err_underflow), .finished(finished)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    finish = 1'b0;
    hs.ap_start = 1'b0; hs.ap_ready = 1'b1; hs.ap_done = 1'b0; hs.ap_continue = 1'b1;
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    repeat (3) tick();
    checks++; if (status !== 2'd0) begin failures++; $display("FAIL reset_status got=%0d exp=0", status); end
    checks++; if (start_cnt !== 0 || done_cnt !== 0 || outstanding !== 0) begin failures++; $display("FAIL reset_counts got=%0d/%0d/%0d exp=0/0/0", start_cnt, done_cnt, outstanding); end
    checks++; if (min_latency !== 32'hFFFF_FFFF || max_latency !== 0) begin failures++; $display("FAIL reset_minmax got=%h/%h exp=ffffffff/0", min_latency, max_latency); end
    checks++; if (lat_valid !== 1'b0 || int_valid !== 1'b0 || err_overflow !== 1'b0 || err_underflow !== 1'b0 || finished !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b%b%b%b exp=00000", lat_valid, int_valid, err_overflow, err_underflow, finished); end
  endtask

  task automatic test_single();
    int n_lat = 0;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      hs.ap_start = (c == 5);
      hs.ap_done  = (c == 12);
      tick();
      n_lat += int'(lat_valid);
      if (c == 6) begin
        checks++; if (status !== 2'd1 || outstanding !== 1) begin failures++; $display("FAIL single_active got=%0d/%0d exp=1/1", status, outstanding); end
      end
      if (c == 12) begin
        checks++; if (lat_valid !== 1'b1 || last_latency !== 7) begin failures++; $display("FAIL single_latency got=%b/%0d exp=1/7", lat_valid, last_latency); end
      end
    end
    checks++; if (n_lat !== 1) begin failures++; $display("FAIL single_lat_pulses got=%0d exp=1", n_lat); end
    checks++; if (min_latency !== 7 || max_latency !== 7) begin failures++; $display("FAIL single_minmax got=%0d/%0d exp=7/7", min_latency, max_latency); end
    checks++; if (start_cnt !== 1 || done_cnt !== 1 || outstanding !== 0) begin failures++; $display("FAIL single_counts got=%0d/%0d/%0d exp=1/1/0", start_cnt, done_cnt, outstanding); end
  endtask

  task automatic test_multi();
    do_reset();
    for (int c = 0; c < 33; c++) begin
      hs.ap_start = (c == 10 || c == 13 || c == 20);
      hs.ap_done  = (c == 15 || c == 17 || c == 30);
      tick();
      if (c == 10) begin
        checks++; if (int_valid !== 1'b0) begin failures++; $display("FAIL multi_first_int got=%b exp=0", int_valid); end
      end
      if (c == 13) begin
        checks++; if (int_valid !== 1'b1 || last_interval !== 3) begin failures++; $display("FAIL multi_int1 got=%b/%0d exp=1/3", int_valid, last_interval); end
      end
      if (c == 20) begin
        checks++; if (int_valid !== 1'b1 || last_interval !== 7) begin failures++; $display("FAIL multi_int2 got=%b/%0d exp=1/7", int_valid, last_interval); end
      end
      if (c == 15) begin
        checks++; if (last_latency !== 5) begin failures++; $display("FAIL multi_lat1 got=%0d exp=5", last_latency); end
      end
      if (c == 17) begin
        checks++; if (last_latency !== 4) begin failures++; $display("FAIL multi_lat2 got=%0d exp=4", last_latency); end
      end
      if (c == 30) begin
        checks++; if (last_latency !== 10) begin failures++; $display("FAIL multi_lat3 got=%0d exp=10", last_latency); end
      end
    end
    checks++; if (min_latency !== 4 || max_latency !== 10) begin failures++; $display("FAIL multi_minmax got=%0d/%0d exp=4/10", min_latency, max_latency); end
    checks++; if (start_cnt !== 3 || done_cnt !== 3 || outstanding !== 0) begin failures++; $display("FAIL multi_counts got=%0d/%0d/%0d exp=3/3/0", start_cnt, done_cnt, outstanding); end
  endtask

  task automatic test_wait_cont();
    int n_wait = 0;
    do_reset();
    for (int c = 0; c < 12; c++) begin
      hs.ap_start    = (c == 2);
      hs.ap_done     = (c >= 5 && c <= 8);
      hs.ap_continue = !(c >= 5 && c <= 7);
      tick();
      if (status === 2'd2) n_wait++;
      if (c == 8) begin
        checks++; if (lat_valid !== 1'b1 || last_latency !== 6) begin failures++; $display("FAIL wait_latency got=%b/%0d exp=1/6", lat_valid, last_latency); end
      end
    end
    checks++; if (n_wait !== 3) begin failures++; $display("FAIL wait_status_cycles got=%0d exp=3", n_wait); end
    checks++; if (done_cnt !== 1 || err_underflow !== 1'b0) begin failures++; $display("FAIL wait_done_cnt got=%0d/%b exp=1/0", done_cnt, err_underflow); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    hs.ap_start = 1'b1; hs.ap_done = 1'b1;
    tick();
    hs.ap_start = 1'b0; hs.ap_done = 1'b0;
    checks++; if (lat_valid !== 1'b1 || last_latency !== 0 || outstanding !== 0) begin failures++; $display("FAIL bypass got=%b/%0d/%0d exp=1/0/0", lat_valid, last_latency, outstanding); end
    checks++; if (err_overflow !== 1'b0 || err_underflow !== 1'b0 || start_cnt !== 1 || done_cnt !== 1) begin failures++; $display("FAIL bypass_flags got=%b%b/%0d/%0d exp=00/1/1", err_overflow, err_underflow, start_cnt, done_cnt); end
    do_reset();
    for (int c = 0; c < 8; c++) begin
      hs.ap_start = (c == 1 || c == 4);
      hs.ap_done  = (c == 4 || c == 6);
      tick();
      if (c == 4) begin
        checks++; if (last_latency !== 3 || outstanding !== 1) begin failures++; $display("FAIL swap_lat got=%0d/%0d exp=3/1", last_latency, outstanding); end
      end
      if (c == 6) begin
        checks++; if (last_latency !== 2 || outstanding !== 0) begin failures++; $display("FAIL swap_lat2 got=%0d/%0d exp=2/0", last_latency, outstanding); end
      end
    end
    // ap_ready low must block acceptance
    hs.ap_ready = 1'b0; hs.ap_start = 1'b1;
    tick();
    hs.ap_start = 1'b0; hs.ap_ready = 1'b1;
    checks++; if (start_cnt !== 2) begin failures++; $display("FAIL ready_low got=%0d exp=2", start_cnt); end
  endtask

  task automatic test_errors();
    do_reset();
    for (int c = 0; c < 5; c++) begin
      hs.ap_start = 1'b1;
      tick();
    end
    hs.ap_start = 1'b0;
    tick();
    checks++; if (err_overflow !== 1'b1 || outstanding !== 4 || start_cnt !== 5) begin failures++; $display("FAIL overflow got=%b/%0d/%0d exp=1/4/5", err_overflow, outstanding, start_cnt); end
    do_reset();
    hs.ap_done = 1'b1;
    tick();
    hs.ap_done = 1'b0;
    checks++; if (err_underflow !== 1'b1 || done_cnt !== 1 || lat_valid !== 1'b0 || min_latency !== 32'hFFFF_FFFF) begin failures++; $display("FAIL underflow got=%b/%0d/%b/%h exp=1/1/0/ffffffff", err_underflow, done_cnt, lat_valid, min_latency); end
  endtask

  task automatic test_finish();
    do_reset();
    hs.ap_start = 1'b1;
    tick();
    hs.ap_start = 1'b0;
    tick();
    finish = 1'b1;
    tick();
    finish = 1'b0;
    for (int c = 0; c < 4; c++) begin
      hs.ap_start = 1'b1; hs.ap_done = 1'b1;
      tick();
      checks++; if (lat_valid !== 1'b0 || int_valid !== 1'b0) begin failures++; $display("FAIL finish_pulses got=%b%b exp=00", lat_valid, int_valid); end
    end
    hs.ap_start = 1'b0; hs.ap_done = 1'b0;
    tick();
    checks++; if (status !== 2'd3 || finished !== 1'b1) begin failures++; $display("FAIL finish_status got=%0d/%b exp=3/1", status, finished); end
    checks++; if (start_cnt !== 1 || done_cnt !== 0 || outstanding !== 1) begin failures++; $display("FAIL finish_frozen got=%0d/%0d/%0d exp=1/0/1", start_cnt, done_cnt, outstanding); end
    reset = 1'b0;
    #2;
    checks++; if (status !== 2'd0 || finished !== 1'b0 || start_cnt !== 0 || outstanding !== 0 || err_overflow !== 1'b0 || err_underflow !== 1'b0) begin failures++; $display("FAIL finish_reset got=%0d/%b/%0d/%0d exp=0/0/0/0", status, finished, start_cnt, outstanding); end
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_wait_cont();
    test_same_cycle();
    test_errors();
    test_finish();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
